volume_level_controller: RTL and testbench



---
 rtl/volume_level_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_volume_level_controller.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/volume_level_controller.sv
// volume_level_controller
// Turns the raw up/down/mute pushbuttons into a saturating 0..MAX_LEVEL
// volume value. Each button is synchronized and debounced. Up/down share
// one hold-to-repeat sequencer. Mute toggles, and an external load port
// overrides everything else.
module volume_level_controller #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 15_000_000,
  parameter int unsigned MAX_LEVEL           = 9,
  parameter int unsigned RESET_LEVEL         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mute,
  input  logic       load_valid,
  input  logic [3:0] load_level,
  output logic [3:0] volume_level,
  output logic       muted,
  output logic       level_changed
);

  // Button lanes inside the packed per-button vectors
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_MUTE = 2;

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Repeat timer counts down from (period - 1) to zero
  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE_CYCLES - 1);

  // Level bounds; the reset level is clamped so it can never exceed the top
  localparam logic [3:0] MAX_LVL = 4'(MAX_LEVEL);
  localparam logic [3:0] RST_LVL = (RESET_LEVEL > MAX_LEVEL) ? 4'(MAX_LEVEL) : 4'(RESET_LEVEL);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync_meta;
  logic [2:0]       sync_stable;
  logic [2:0]       db_state;
  logic [2:0]       db_prev;
  logic [2:0]       press;
  logic [DEB_W-1:0] deb_cnt [3];

  rpt_state_t       rpt_state;
  logic             rpt_dir_up;
  logic [TMR_W-1:0] rpt_timer;
  logic             active_held;
  logic             opposite_held;
  logic             step_up;
  logic             step_down;

  logic [3:0]       stored_level;
  logic [3:0]       level_next;
  logic             muted_next;
  logic [3:0]       load_clamped;
  logic [3:0]       vol_prev;

  assign btn_raw = {btn_mute, btn_down, btn_up};

  // Two-flop synchronizer bringing the asynchronous buttons into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta   <= '0;
      sync_stable <= '0;
    end else begin
      sync_meta   <= btn_raw;
      sync_stable <= sync_meta;
    end
  end

  // Debouncer: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      db_state <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      db_prev <= db_state;
      for (int i = 0; i < 3; i++) begin
        if (sync_stable[i] == db_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]  <= '0;
          db_state[i] <= ~db_state[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // A press is the cycle right after a debounced 0->1 transition; releases are silent
  assign press = db_state & ~db_prev;

  // Which direction the sequencer is following, and whether the other one interferes
  assign active_held   = rpt_dir_up ? db_state[BTN_UP]   : db_state[BTN_DOWN];
  assign opposite_held = rpt_dir_up ? db_state[BTN_DOWN] : db_state[BTN_UP];

  // Step requests: initial press from idle, or a timer expiry while still holding
  always_comb begin
    step_up   = 1'b0;
    step_down = 1'b0;
    case (rpt_state)
      RPT_IDLE: begin
        if (press[BTN_UP] && !db_state[BTN_DOWN]) begin
          step_up = 1'b1;
        end else if (press[BTN_DOWN] && !db_state[BTN_UP]) begin
          step_down = 1'b1;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (active_held && !opposite_held && (rpt_timer == '0)) begin
          step_up   = rpt_dir_up;
          step_down = ~rpt_dir_up;
        end
      end
      default: begin
        step_up   = 1'b0;
        step_down = 1'b0;
      end
    endcase
  end

  // Hold-to-repeat sequencer shared by the up and down buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_state  <= RPT_IDLE;
      rpt_dir_up <= 1'b0;
      rpt_timer  <= '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          if (step_up || step_down) begin
            rpt_state  <= RPT_DELAY;
            rpt_dir_up <= step_up;
            rpt_timer  <= DELAY_LOAD;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (!active_held || opposite_held) begin
            rpt_state <= RPT_IDLE;
            rpt_timer <= '0;
          end else if (rpt_timer == '0) begin
            rpt_state <= RPT_REPEAT;
            rpt_timer <= RATE_LOAD;
          end else begin
            rpt_timer <= rpt_timer - TMR_W'(1);
          end
        end
        default: begin
          rpt_state <= RPT_IDLE;
          rpt_timer <= '0;
        end
      endcase
    end
  end

  assign load_clamped = (load_level > MAX_LVL) ? MAX_LVL : load_level;

  // Next level/mute: load beats mute toggle beats step; a step while muted only unmutes
  always_comb begin
    level_next = stored_level;
    muted_next = muted;
    if (load_valid) begin
      level_next = load_clamped;
      muted_next = 1'b0;
    end else if (press[BTN_MUTE]) begin
      muted_next = ~muted;
    end else if (step_up || step_down) begin
      if (muted) begin
        muted_next = 1'b0;
      end else if (step_up) begin
        if (stored_level < MAX_LVL) begin
          level_next = stored_level + 4'd1;
        end
      end else begin
        if (stored_level != 4'd0) begin
          level_next = stored_level - 4'd1;
        end
      end
    end
  end

  // Registered level, mute and effective output, plus the one-cycle change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      stored_level  <= RST_LVL;
      muted         <= 1'b0;
      volume_level  <= RST_LVL;
      vol_prev      <= RST_LVL;
      level_changed <= 1'b0;
    end else begin
      stored_level  <= level_next;
      muted         <= muted_next;
      volume_level  <= muted_next ? 4'd0 : level_next;
      vol_prev      <= volume_level;
      level_changed <= (volume_level != vol_prev);
    end
  end

  // The stored level must never leave the 0..MAX_LEVEL range
  assert property (@(posedge clk) disable iff (rst) (stored_level <= MAX_LVL));

  // While muted the effective output is forced to zero
  assert property (@(posedge clk) disable iff (rst) (!muted || (volume_level == 4'd0)));

endmodule

// File: tb/tb_volume_level_controller.sv
// tb_volume_level_controller
// Drives the volume controller with small timing parameters, checks directed
// sequences against hand-derived values and every cycle against a behavioural
// model built from debounce windows and step schedules.
module tb_volume_level_controller;

  localparam int DEB   = 4;
  localparam int DELAY = 20;
  localparam int RATE  = 5;
  localparam int MAXL  = 9;
  localparam int RSTL  = 0;
  localparam int HIST  = 8192;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_mute;
  logic       load_valid;
  logic [3:0] load_level;
  logic [3:0] volume_level;
  logic       muted;
  logic       level_changed;

  int checks;
  int errors;

  volume_level_controller #(
    .DEBOUNCE_CYCLES    (DEB),
    .REPEAT_DELAY_CYCLES(DELAY),
    .REPEAT_RATE_CYCLES (RATE),
    .MAX_LEVEL          (MAXL),
    .RESET_LEVEL        (RSTL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_mute     (btn_mute),
    .load_valid   (load_valid),
    .load_level   (load_level),
    .volume_level (volume_level),
    .muted        (muted),
    .level_changed(level_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference state
  bit       raw_hist [3][HIST];
  int       edge_no;
  int       rst_edge;
  bit [2:0] m_db;
  bit [2:0] m_db_old;
  int       rep_dir;
  int       next_step;
  int       m_level;
  bit       m_muted;
  int       m_vol;
  int       m_vol_prev;
  bit       m_changed;

  typedef struct {
    bit         lv;
    logic [3:0] ll;
    int         exp_vol;
    bit         exp_muted;
    bit         exp_chg;
  } load_vec_t;

  load_vec_t vecs [11];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit up, input bit down, input bit mute,
                               input bit lv, input logic [3:0] ll);
    btn_up     = up;
    btn_down   = down;
    btn_mute   = mute;
    load_valid = lv;
    load_level = ll;
  endtask

  // Synchronized sample the debouncer compares on edge e: the raw value two edges earlier
  function automatic bit sample_at(input int b, input int e);
    int idx;
    idx = e - 2;
    if (idx < 0 || idx <= rst_edge) return 1'b0;
    return raw_hist[b][idx];
  endfunction

  task automatic model_reset();
    rst_edge   = edge_no;
    m_db       = '0;
    m_db_old   = '0;
    rep_dir    = 0;
    next_step  = 0;
    m_level    = RSTL;
    m_muted    = 1'b0;
    m_vol      = RSTL;
    m_vol_prev = RSTL;
    m_changed  = 1'b0;
  endtask

  task automatic model_edge();
    bit [2:0] press_ev;
    bit [2:0] new_db;
    bit       held_up;
    bit       held_down;
    bit       s_up;
    bit       s_down;
    bit       all_diff;
    int       new_vol;
    if (edge_no >= HIST) begin
      $display("[TB] FAIL history_overflow: got %0d expected below %0d", edge_no, HIST);
      $fatal(1, "[TB] history exhausted");
    end
    raw_hist[0][edge_no] = btn_up;
    raw_hist[1][edge_no] = btn_down;
    raw_hist[2][edge_no] = btn_mute;
    if (rst) begin
      model_reset();
    end else begin
      press_ev  = m_db & ~m_db_old;
      held_up   = m_db[0];
      held_down = m_db[1];
      s_up      = 1'b0;
      s_down    = 1'b0;
      if (rep_dir == 0) begin
        if (press_ev[0] && !held_down) begin
          s_up = 1'b1; rep_dir = 1; next_step = edge_no + DELAY;
        end else if (press_ev[1] && !held_up) begin
          s_down = 1'b1; rep_dir = 2; next_step = edge_no + DELAY;
        end
      end else begin
        if ((rep_dir == 1 && (!held_up || held_down)) ||
            (rep_dir == 2 && (!held_down || held_up))) begin
          rep_dir = 0;
        end else if (edge_no == next_step) begin
          s_up      = (rep_dir == 1);
          s_down    = (rep_dir == 2);
          next_step = edge_no + RATE;
        end
      end
      if (load_valid) begin
        m_level = (int'(load_level) > MAXL) ? MAXL : int'(load_level);
        m_muted = 1'b0;
      end else if (press_ev[2]) begin
        m_muted = !m_muted;
      end else if (s_up || s_down) begin
        if (m_muted) m_muted = 1'b0;
        else if (s_up) m_level = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
        else m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
      end
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (sample_at(b, edge_no - k) == m_db[b]) all_diff = 1'b0;
        end
        new_db[b] = all_diff ? !m_db[b] : m_db[b];
      end
      m_db_old   = m_db;
      m_db       = new_db;
      new_vol    = m_muted ? 0 : m_level;
      m_changed  = (m_vol != m_vol_prev);
      m_vol_prev = m_vol;
      m_vol      = new_vol;
    end
    edge_no++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      checkOutput("model_volume", int'(volume_level), m_vol);
      checkOutput("model_muted", int'(muted), int'(m_muted));
      checkOutput("model_changed", int'(level_changed), int'(m_changed));
    end
  endtask

  task automatic setButton(input int idx, input bit val);
    case (idx)
      0:       btn_up   = val;
      1:       btn_down = val;
      default: btn_mute = val;
    endcase
  endtask

  task automatic pressButton(input int idx);
    setButton(idx, 1'b1);
    tick(8);
    setButton(idx, 1'b0);
    tick(10);
  endtask

  task automatic loadLevel(input logic [3:0] lvl);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, lvl);
    tick(1);
    load_valid = 1'b0;
    tick(2);
  endtask

  initial begin
    int span;
    checks   = 0;
    errors   = 0;
    edge_no  = 0;
    rst_edge = -1;
    model_reset();

    vecs[0]  = '{1'b1, 4'd3,  3, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  3, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 4'd12, 9, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd9,  9, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'd15, 9, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd0,  0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'd0,  0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd5,  5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  5, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  5, 1'b0, 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checkOutput("reset_volume", int'(volume_level), 0);
    checkOutput("reset_muted", int'(muted), 0);
    checkOutput("reset_changed", int'(level_changed), 0);

    // Load port: clamping, change pulse one cycle after the new value
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, vecs[i].lv, vecs[i].ll);
      tick(1);
      checkOutput($sformatf("vec%0d_volume", i), int'(volume_level), vecs[i].exp_vol);
      checkOutput($sformatf("vec%0d_muted", i), int'(muted), int'(vecs[i].exp_muted));
      checkOutput($sformatf("vec%0d_changed", i), int'(level_changed), int'(vecs[i].exp_chg));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Single up press: level moves 7 edges after the raw rise, one pulse, nothing on release
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      checkOutput($sformatf("press_volume_k%0d", k), int'(volume_level), (k >= 7) ? 1 : 0);
      checkOutput($sformatf("press_pulse_k%0d", k), int'(level_changed), (k == 8) ? 1 : 0);
    end
    btn_up = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      checkOutput($sformatf("release_volume_k%0d", k), int'(volume_level), 1);
      checkOutput($sformatf("release_pulse_k%0d", k), int'(level_changed), 0);
    end

    // Short glitch on down is rejected; then a long up hold auto-repeats to the top
    loadLevel(4'd3);
    btn_down = 1'b1;
    tick(3);
    btn_down = 1'b0;
    tick(10);
    checkOutput("glitch_volume", int'(volume_level), 3);
    btn_up = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      int exp_lvl;
      bit exp_pulse;
      tick(1);
      exp_lvl = 3;
      if (k >= 7) exp_lvl = 4;
      if (k >= 27) exp_lvl = 5 + (k - 27) / 5;
      if (exp_lvl > 9) exp_lvl = 9;
      exp_pulse = (k == 8) || (k >= 28 && k <= 48 && ((k - 28) % 5) == 0);
      checkOutput($sformatf("hold_volume_k%0d", k), int'(volume_level), exp_lvl);
      checkOutput($sformatf("hold_pulse_k%0d", k), int'(level_changed), int'(exp_pulse));
    end
    btn_up = 1'b0;
    tick(12);

    // Mute toggling retains the stored level; a step while muted only unmutes
    loadLevel(4'd5);
    pressButton(2);
    checkOutput("mute1_volume", int'(volume_level), 0);
    checkOutput("mute1_muted", int'(muted), 1);
    pressButton(2);
    checkOutput("mute2_volume", int'(volume_level), 5);
    checkOutput("mute2_muted", int'(muted), 0);
    pressButton(2);
    checkOutput("mute3_muted", int'(muted), 1);
    pressButton(1);
    checkOutput("unmute_down_volume", int'(volume_level), 5);
    checkOutput("unmute_down_muted", int'(muted), 0);

    // Load on the same edge as a mute press: load wins and the toggle is dropped
    pressButton(2);
    checkOutput("premute_muted", int'(muted), 1);
    btn_mute = 1'b1;
    tick(6);
    checkOutput("before_event_muted", int'(muted), 1);
    load_valid = 1'b1;
    load_level = 4'd12;
    tick(1);
    load_valid = 1'b0;
    checkOutput("load_vs_mute_volume", int'(volume_level), 9);
    checkOutput("load_vs_mute_muted", int'(muted), 0);
    tick(2);
    btn_mute = 1'b0;
    tick(10);
    checkOutput("after_load_muted", int'(muted), 0);
    checkOutput("after_load_volume", int'(volume_level), 9);

    // Simultaneous up+down does nothing; down during up auto-repeat stops it
    loadLevel(4'd4);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(10);
    checkOutput("both_volume", int'(volume_level), 4);
    btn_up = 1'b1;
    tick(32);
    checkOutput("repeat_mid_volume", int'(volume_level), 7);
    btn_down = 1'b1;
    tick(30);
    checkOutput("repeat_stopped_volume", int'(volume_level), 8);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(12);
    checkOutput("repeat_released_volume", int'(volume_level), 8);

    // Reset during a hold: back to zero, then a fresh debounce gives one step
    loadLevel(4'd6);
    btn_up = 1'b1;
    tick(12);
    checkOutput("pre_reset_volume", int'(volume_level), 7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("mid_reset_volume", int'(volume_level), 0);
    checkOutput("mid_reset_muted", int'(muted), 0);
    checkOutput("mid_reset_changed", int'(level_changed), 0);
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      checkOutput($sformatf("redebounce_volume_k%0d", k), int'(volume_level), (k == 7) ? 1 : 0);
    end
    btn_up = 1'b0;
    tick(12);

    // Randomized buttons, loads and occasional resets against the model
    span = 10;
    for (int i = 0; i < 2400; i++) begin
      if ((i % 200) == 0) begin
        case ($urandom_range(0, 2))
          0:       span = 3;
          1:       span = 10;
          default: span = 40;
        endcase
      end
      if ($urandom_range(0, span) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, span) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, span) == 0) btn_mute = ~btn_mute;
      load_valid = ($urandom_range(0, 49) == 0);
      load_level = 4'($urandom_range(0, 15));
      rst        = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
